// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared decode constants and multiplier FSM state type
// Imported by the EX-stage multiplier and its shift-add datapath.
package cpu_pkg;

   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

   localparam logic [2:0] FUNC3_MUL    = 3'b000;
   localparam logic [2:0] FUNC3_MULH   = 3'b001;
   localparam logic [2:0] FUNC3_MULHSU = 3'b010;
   localparam logic [2:0] FUNC3_MULHU  = 3'b011;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mul_state_t;

endpackage : cpu_pkg

// File: rtl/mul_shift_add_core.sv
// rtl/mul_shift_add_core.sv - unsigned shift-add multiplier datapath
// One partial product per step; prod_next_o is the accumulator value after the current step.
module mul_shift_add_core
   import cpu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              step_i,
   input  logic [XLEN-1:0]   mcand_i,
   input  logic [XLEN-1:0]   mplier_i,
   output logic              step_done_o,
   output logic [2*XLEN-1:0] prod_next_o
);

   localparam int CW = $clog2(XLEN);

   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [2*XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]     count_q, count_d;
   logic [2*XLEN-1:0] sum;

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
      if (start_i) begin
         acc_d    = '0;
         mcand_d  = {{XLEN{1'b0}}, mcand_i};
         mplier_d = mplier_i;
         count_d  = '0;
      end else if (step_i) begin
         acc_d    = sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = count_q + 1'b1;
      end
   end

   // The last step's sum is handed straight out so the result can be captured on that same edge.
   assign step_done_o = step_i & (count_q == CW'(XLEN - 1));
   assign prod_next_o = sum;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
      end
   end

endmodule : mul_shift_add_core

// File: rtl/ex_mul_unit.sv
// rtl/ex_mul_unit.sv - iterative RV32M multiplier in the EX stage
// Stalls the front end while the shift-add core runs, then pulses done_o with the registered result.
module ex_mul_unit
   import cpu_pkg::*;
#(
   parameter int         XLEN      = 32,
   parameter logic [1:0] MUL_ALUOP = ALUOP_RTYPE,
   parameter logic [6:0] MUL_FUNC7 = FUNC7_MULDIV
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   input  logic            flush_i,
   input  logic [1:0]      ALUOp_i,
   input  logic [6:0]      func7_i,
   input  logic [2:0]      func3_i,
   input  logic [XLEN-1:0] RS1data_i,
   input  logic [XLEN-1:0] RS2data_i,
   input  logic [4:0]      RegisterRd_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      RegisterRd_o
);

   mul_state_t        state_q, state_d;
   logic              neg_q, neg_d;
   logic [2:0]        func3_q, func3_d;
   logic [4:0]        rd_q, rd_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [4:0]        rd_out_q, rd_out_d;

   logic              mul_req;
   logic              signed_a, signed_b, a_neg, b_neg;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic              start, step, step_done;
   logic [2*XLEN-1:0] prod_next, prod_fixed;

   assign mul_req = valid_i & ~flush_i & (ALUOp_i == MUL_ALUOP) &
                    (func7_i == MUL_FUNC7) & ~func3_i[2];

   // MUL takes the unsigned path: the low half is identical for any signedness.
   assign signed_a = (func3_i == FUNC3_MULH) | (func3_i == FUNC3_MULHSU);
   assign signed_b = (func3_i == FUNC3_MULH);
   assign a_neg    = signed_a & RS1data_i[XLEN-1];
   assign b_neg    = signed_b & RS2data_i[XLEN-1];
   assign abs_a    = a_neg ? -RS1data_i : RS1data_i;
   assign abs_b    = b_neg ? -RS2data_i : RS2data_i;

   assign step       = (state_q == BUSY) & ~flush_i;
   assign prod_fixed = neg_q ? -prod_next : prod_next;

   mul_shift_add_core #(.XLEN(XLEN)) u_core (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start),
      .step_i     (step),
      .mcand_i    (abs_a),
      .mplier_i   (abs_b),
      .step_done_o(step_done),
      .prod_next_o(prod_next)
   );

   always_comb begin
      state_d  = state_q;
      neg_d    = neg_q;
      func3_d  = func3_q;
      rd_d     = rd_q;
      result_d = result_q;
      rd_out_d = rd_out_q;
      start    = 1'b0;
      stall_o  = 1'b0;
      done_o   = 1'b0;
      unique case (state_q)
         IDLE: begin
            stall_o = mul_req;
            if (mul_req) begin
               start   = 1'b1;
               neg_d   = a_neg ^ b_neg;
               func3_d = func3_i;
               rd_d    = RegisterRd_i;
               state_d = BUSY;
            end
         end
         BUSY: begin
            stall_o = 1'b1;
            if (flush_i) begin
               state_d = IDLE;
            end else if (step_done) begin
               result_d = (func3_q == FUNC3_MUL) ? prod_fixed[XLEN-1:0]
                                                 : prod_fixed[2*XLEN-1:XLEN];
               rd_out_d = rd_q;
               state_d  = DONE;
            end
         end
         DONE: begin
            done_o  = ~flush_i;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Reset must release the front end immediately, even before the state flop settles.
      if (rst_i) stall_o = 1'b0;
   end

   assign result_o     = result_q;
   assign RegisterRd_o = rd_out_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         neg_q    <= 1'b0;
         func3_q  <= '0;
         rd_q     <= '0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state_q  <= state_d;
         neg_q    <= neg_d;
         func3_q  <= func3_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
      end
   end

endmodule : ex_mul_unit

// File: tb/tb_ex_mul_unit.sv
// tb/tb_ex_mul_unit.sv - directed vector bench for ex_mul_unit
// Table of multiplies plus hand-written flush, reset, pass-through and back-to-back sequences.
module tb_ex_mul_unit;

   logic        clk = 1'b0;
   logic        rst_i, valid_i, flush_i;
   logic [1:0]  ALUOp_i;
   logic [6:0]  func7_i;
   logic [2:0]  func3_i;
   logic [31:0] RS1data_i, RS2data_i;
   logic [4:0]  RegisterRd_i;
   logic        stall_o, done_o;
   logic [31:0] result_o;
   logic [4:0]  RegisterRd_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_mul_unit dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .flush_i     (flush_i),
      .ALUOp_i     (ALUOp_i),
      .func7_i     (func7_i),
      .func3_i     (func3_i),
      .RS1data_i   (RS1data_i),
      .RS2data_i   (RS2data_i),
      .RegisterRd_i(RegisterRd_i),
      .stall_o     (stall_o),
      .done_o      (done_o),
      .result_o    (result_o),
      .RegisterRd_o(RegisterRd_o)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
      valid_i      = 1'b1;
      ALUOp_i      = 2'b10;
      func7_i      = 7'b0000001;
      func3_i      = f3;
      RS1data_i    = a;
      RS2data_i    = b;
      RegisterRd_i = rd;
   endtask

   // Entered just after a posedge; returns just after a posedge with valid_i dropped.
   task automatic run_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int stalls, output int done_at);
      stalls  = 0;
      done_at = -1;
      drive_mul(f3, a, b, rd);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (stall_o) stalls++;
         if (done_o) done_at = c;
         @(posedge clk);
         #1;
         if (done_at >= 0) break;
      end
      valid_i = 1'b0;
   endtask

   initial begin
      int stalls, done_at, bad, d0, d1;
      logic [31:0] last_exp;
      logic [4:0]  last_rd;

      vecs[0] = '{3'b000, 32'h0000_0007, 32'h0000_0006, 5'd5,  32'h0000_002A};
      vecs[1] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
      vecs[2] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000};
      vecs[3] = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFE};
      vecs[4] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF};
      vecs[5] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE};
      vecs[6] = '{3'b011, 32'h8000_0000, 32'h0000_0002, 5'd7,  32'h0000_0001};
      vecs[7] = '{3'b001, 32'h8000_0000, 32'h0000_0001, 5'd8,  32'hFFFF_FFFF};
      vecs[8] = '{3'b010, 32'h8000_0000, 32'h8000_0000, 5'd31, 32'hC000_0000};

      rst_i   = 1'b1;
      flush_i = 1'b0;
      drive_mul(3'b000, 32'd7, 32'd6, 5'd5);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_stall", {31'd0, stall_o}, 32'd0);
      chk("reset_done", {31'd0, done_o}, 32'd0);
      chk("reset_result", result_o, 32'd0);
      chk("reset_rd", {27'd0, RegisterRd_o}, 32'd0);
      valid_i = 1'b0;
      rst_i   = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         run_mul(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, stalls, done_at);
         chk($sformatf("v%0d_stall_cycles", i), stalls, 33);
         chk($sformatf("v%0d_done_cycle", i), done_at, 33);
         chk($sformatf("v%0d_result", i), result_o, vecs[i].exp);
         chk($sformatf("v%0d_rd", i), {27'd0, RegisterRd_o}, {27'd0, vecs[i].rd});
      end
      last_exp = vecs[8].exp;
      last_rd  = vecs[8].rd;

      // Flush in BUSY cycle 10
      drive_mul(3'b000, 32'd9, 32'd9, 5'd12);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      flush_i = 1'b1;
      @(negedge clk);
      chk("flush_stall_c10", {31'd0, stall_o}, 32'd1);
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      valid_i = 1'b0;
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (stall_o || done_o) bad++;
      end
      chk("flush_quiet", bad, 0);
      chk("flush_result_kept", result_o, last_exp);
      chk("flush_rd_kept", {27'd0, RegisterRd_o}, {27'd0, last_rd});
      @(posedge clk);
      #1;

      // Reset in BUSY cycle 20
      drive_mul(3'b000, 32'd5, 32'd5, 5'd9);
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      valid_i = 1'b0;
      rst_i   = 1'b1;
      #1;
      chk("rst_mid_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_mid_done", {31'd0, done_o}, 32'd0);
      chk("rst_mid_result", result_o, 32'd0);
      chk("rst_mid_rd", {27'd0, RegisterRd_o}, 32'd0);
      @(negedge clk);
      rst_i = 1'b0;
      @(posedge clk);
      #1;
      run_mul(3'b000, 32'd3, 32'd3, 5'd10, stalls, done_at);
      chk("after_rst_done_cycle", done_at, 33);
      chk("after_rst_result", result_o, 32'h0000_0009);

      // Non-multiply traffic passes through
      for (int p = 0; p < 3; p++) begin
         drive_mul(3'b000, 32'd4, 32'd4, 5'd11);
         if (p == 0) func7_i = 7'b0000000;
         if (p == 1) valid_i = 1'b0;
         if (p == 2) func3_i = 3'b100;
         bad = 0;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (stall_o || done_o) bad++;
            @(posedge clk);
            #1;
         end
         chk($sformatf("passthru_%0d", p), bad, 0);
      end
      valid_i = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back multiplies
      d0 = -1;
      d1 = -1;
      drive_mul(3'b000, 32'd7, 32'd6, 5'd5);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done_o && d0 < 0) begin
            d0 = c;
            chk("b2b_first_result", result_o, 32'h0000_002A);
         end else if (done_o && d1 < 0) begin
            d1 = c;
            chk("b2b_second_result", result_o, 32'h0000_008F);
            chk("b2b_second_rd", {27'd0, RegisterRd_o}, 32'd7);
         end
         @(posedge clk);
         #1;
         if (d1 >= 0) break;
         if (d0 == c) drive_mul(3'b000, 32'd11, 32'd13, 5'd7);
      end
      valid_i = 1'b0;
      chk("b2b_first_cycle", d0, 33);
      chk("b2b_spacing", d1 - d0, 34);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ex_mul_unit
